// File: rtl/ram_uart_pkg.sv
// ============================================================================
// ram_uart_pkg : shared FSM encoding and widths for the RAM-row-to-UART block
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ROW_REQ  = 3'd1,
    ST_ROW_WAIT = 3'd2,
    ST_FETCH    = 3'd3,
    ST_SEND     = 3'd4,
    ST_TX_GAP   = 3'd5,
    ST_TX_WAIT  = 3'd6,
    ST_ACK_WAIT = 3'd7
  } state_t;

  localparam logic [7:0]  ACK_BYTE_DEFAULT = 8'h41;
  localparam int unsigned IDX_W            = 9;
  localparam int unsigned TIMER_W          = 24;
  localparam int unsigned RETRY_W          = 2;

endpackage

`default_nettype wire

// File: rtl/ack_timeout_cnt.sv
// ============================================================================
// ack_timeout_cnt : per-row ack timer and retransmission counter
// Rev 1.0
// ============================================================================
`default_nettype none

module ack_timeout_cnt
  import ram_uart_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 12_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic clk_12m,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic retry_exhausted
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  assign expired         = en && (timer_q == TIMER_LAST);
  assign retry_exhausted = (retry_q == RETRY_MAX);

  // Timer restarts from zero whenever the wait window is not open, so every
  // ACK_WAIT visit gets a full timeout. Neither counter can pass its limit.
  always_comb begin
    timer_d = timer_q;
    retry_d = retry_q;
    if (clr) begin
      timer_d = '0;
      retry_d = '0;
    end else if (!en) begin
      timer_d = '0;
    end else if (expired) begin
      timer_d = '0;
      if (!retry_exhausted) retry_d = retry_q + 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_row_to_uart.sv
// ============================================================================
// ram_row_to_uart : streams RAM rows to a UART, one host ack per row, retries
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_row_to_uart
  import ram_uart_pkg::*;
#(
  parameter int unsigned ROW_BYTES   = 480,
  parameter int unsigned ROW_COUNT   = 320,
  parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 12_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk_12m,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       row_ready,
  input  logic [7:0] rd_data,
  input  logic       tx_busy,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data_out,
  output logic [8:0] rd_addr,
  output logic       row_req,
  output logic [8:0] row_idx,
  output logic       tx_data_valid,
  output logic [7:0] tx_data_out,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(ROW_BYTES - 1);
  localparam logic [IDX_W-1:0] ROW_LAST  = IDX_W'(ROW_COUNT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             row_req_q, row_req_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic ack_hit, tmo_expired, retry_exhausted, cnt_clr, cnt_en;

  assign ack_hit = (state_q == ST_ACK_WAIT) && rx_data_valid && (rx_data_out == ACK_BYTE);
  assign cnt_en  = (state_q == ST_ACK_WAIT);
  assign cnt_clr = abort || ack_hit || (state_q == ST_IDLE);

  ack_timeout_cnt #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) u_ack_cnt (
    .clk_12m         (clk_12m),
    .rst_n           (rst_n),
    .clr             (cnt_clr),
    .en              (cnt_en),
    .expired         (tmo_expired),
    .retry_exhausted (retry_exhausted)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    row_idx_d  = row_idx_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    row_req_d  = 1'b0;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_ROW_REQ;
            row_req_d = 1'b1;
          end
        end
        ST_ROW_REQ:  state_d = ST_ROW_WAIT;
        ST_ROW_WAIT: begin
          if (row_ready) begin
            state_d   = ST_FETCH;
            rd_addr_d = byte_idx_q;
          end
        end
        ST_FETCH: state_d = ST_SEND;
        // rd_addr is held through SEND so rd_data stays valid while tx_busy stalls.
        ST_SEND: begin
          if (!tx_busy) begin
            tx_data_d  = rd_data;
            tx_valid_d = 1'b1;
            state_d    = ST_TX_GAP;
          end
        end
        ST_TX_GAP: state_d = ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (!tx_busy) begin
            if (byte_idx_q < BYTE_LAST) begin
              byte_idx_d = byte_idx_q + 1'b1;
              rd_addr_d  = byte_idx_q + 1'b1;
              state_d    = ST_FETCH;
            end else begin
              byte_idx_d = '0;
              state_d    = ST_ACK_WAIT;
            end
          end
        end
        ST_ACK_WAIT: begin
          if (ack_hit) begin
            if (row_idx_q == ROW_LAST) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              row_idx_d = row_idx_q + 1'b1;
              row_req_d = 1'b1;
              state_d   = ST_ROW_REQ;
            end
          end else if (tmo_expired) begin
            if (retry_exhausted) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              byte_idx_d = '0;
              rd_addr_d  = '0;
              state_d    = ST_FETCH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Every path into IDLE leaves the datapath outputs and counters at zero.
    if (state_d == ST_IDLE) begin
      byte_idx_d = '0;
      row_idx_d  = '0;
      rd_addr_d  = '0;
      tx_data_d  = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      row_idx_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      row_req_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      row_idx_q  <= row_idx_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      row_req_q  <= row_req_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rd_addr       = rd_addr_q;
  assign row_req       = row_req_q;
  assign row_idx       = row_idx_q;
  assign tx_data_valid = tx_valid_q;
  assign tx_data_out   = tx_data_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;

endmodule

`default_nettype wire
